// File: rtl/iopll_seq_pkg.sv
// Shared types and sizing helpers for the I/O PLL lock sequencer.
package iopll_seq_pkg;

  localparam int STATE_W = 3;
  localparam int CNT_W   = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_ASSERT_RST = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_STABLE     = 3'd2,
    ST_RUN        = 3'd3,
    ST_FAIL       = 3'd4
  } seq_state_e;

  // Width of the shared cycle counter: enough for the longest of the three
  // cycle parameters, plus one bit of headroom.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/iopll_lock_sync.sv
// Multi-flop synchronizer for a single asynchronous level, reset to 0.
module iopll_lock_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous level through STAGES flops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[STAGES-2:0], async_i};
  end

  assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/iopll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for lock with a
// timeout, qualifies lock stability, then releases the downstream reset.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ASSERT_RST | pll_rst held high for RST_PULSE_CYCLES
// WAIT_LOCK  | pll_rst released, waiting for synchronized lock (timeout)
// STABLE     | lock seen, counting consecutive locked cycles
// RUN        | user_rst released, monitoring for loss of lock
// FAIL       | retries exhausted, PLL held in reset until sw_relock
module iopll_lock_sequencer
  import iopll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3,
  parameter int SYNC_STAGES         = 2
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               sw_relock,
  output logic               pll_rst,
  output logic               user_rst,
  output logic               ready,
  output logic               fail,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   retry_cnt,
  output logic [CNT_W-1:0]   lock_loss_cnt
);

  localparam int CW = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
  localparam logic [CW-1:0]    RST_LAST    = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0]    TO_LAST     = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]    STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RETRY_MAX   = CNT_W'(MAX_RETRIES);

  seq_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] retry_q, retry_d;
  logic [CNT_W-1:0] loss_q, loss_d;
  logic             pll_rst_q, user_rst_q, ready_q, fail_q;
  logic             lock_s;

  iopll_lock_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk_i   (refclk),
    .rst_i   (rst),
    .async_i (pll_locked),
    .sync_o  (lock_s)
  );

  // Next-state, counter and retry/loss bookkeeping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    if (sw_relock) begin
      state_d = ST_ASSERT_RST;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        ST_ASSERT_RST: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            // The cycle that sees lock counts as the first stable cycle.
            state_d = ST_STABLE;
            cnt_d   = CW'(1);
          end else if (cnt_q == TO_LAST) begin
            retry_d = retry_q + CNT_W'(1);
            cnt_d   = '0;
            state_d = (retry_q + CNT_W'(1) == RETRY_MAX) ? ST_FAIL : ST_ASSERT_RST;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q >= STABLE_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_d = ST_ASSERT_RST;
            cnt_d   = '0;
            if (loss_q != '1) loss_d = loss_q + CNT_W'(1);
          end
        end
        ST_FAIL: ;
        default: begin
          state_d = ST_ASSERT_RST;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_ASSERT_RST;
      cnt_q      <= '0;
      retry_q    <= '0;
      loss_q     <= '0;
      pll_rst_q  <= 1'b1;
      user_rst_q <= 1'b1;
      ready_q    <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      loss_q     <= loss_d;
      pll_rst_q  <= (state_d == ST_ASSERT_RST) || (state_d == ST_FAIL);
      user_rst_q <= (state_d != ST_RUN);
      ready_q    <= (state_d == ST_RUN);
      fail_q     <= (state_d == ST_FAIL);
    end
  end

  assign state         = state_q;
  assign retry_cnt     = retry_q;
  assign lock_loss_cnt = loss_q;
  assign pll_rst       = pll_rst_q;
  assign user_rst      = user_rst_q;
  assign ready         = ready_q;
  assign fail          = fail_q;

endmodule

// File: tb/tb_iopll_lock_sequencer.sv
// Directed bench for the PLL lock sequencer with small cycle parameters.
module tb_iopll_lock_sequencer;

  logic       refclk;
  logic       rst;
  logic       pll_locked;
  logic       sw_relock;
  logic       pll_rst;
  logic       user_rst;
  logic       ready;
  logic       fail;
  logic [2:0] state;
  logic [7:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  int checks = 0;
  int errors = 0;

  iopll_lock_sequencer #(
    .RST_PULSE_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES (20),
    .LOCK_STABLE_CYCLES  (8),
    .MAX_RETRIES         (2),
    .SYNC_STAGES         (2)
  ) dut (
    .refclk        (refclk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .sw_relock     (sw_relock),
    .pll_rst       (pll_rst),
    .user_rst      (user_rst),
    .ready         (ready),
    .fail          (fail),
    .state         (state),
    .retry_cnt     (retry_cnt),
    .lock_loss_cnt (lock_loss_cnt)
  );

  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] exp, input int max, input string tag);
    int n;
    n = 0;
    while (state !== exp && n < max) begin
      cyc(1);
      n++;
    end
    chk(tag, {29'd0, state}, {29'd0, exp});
  endtask

  initial begin
    int to_cnt;
    int n;
    logic exp_prst;

    rst = 1'b1; pll_locked = 1'b0; sw_relock = 1'b0;
    cyc(2);
    chk("rst_state",    {29'd0, state}, 32'd0);
    chk("rst_pll_rst",  {31'd0, pll_rst}, 32'd1);
    chk("rst_user_rst", {31'd0, user_rst}, 32'd1);
    chk("rst_ready",    {31'd0, ready}, 32'd0);
    chk("rst_fail",     {31'd0, fail}, 32'd0);
    chk("rst_retry",    {24'd0, retry_cnt}, 32'd0);
    chk("rst_loss",     {24'd0, lock_loss_cnt}, 32'd0);

    // Nominal lock: pll_locked rises 10 cycles after release.
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      chk($sformatf("nom_pll_rst_%0d", k), {31'd0, pll_rst}, {31'd0, (k <= 3)});
    end
    pll_locked = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      chk($sformatf("nom_ready_%0d", k), {31'd0, ready}, {31'd0, (k == 10)});
      chk($sformatf("nom_user_rst_%0d", k), {31'd0, user_rst}, {31'd0, (k != 10)});
    end
    chk("nom_state", {29'd0, state}, 32'd3);
    chk("nom_retry", {24'd0, retry_cnt}, 32'd0);

    // Glitchy lock: one-cycle drop while STABLE counts.
    rst = 1'b1; pll_locked = 1'b0;
    cyc(1);
    rst = 1'b0;
    cyc(10);
    pll_locked = 1'b1;
    cyc(5);
    pll_locked = 1'b0;
    cyc(1);
    pll_locked = 1'b1;
    cyc(2);
    chk("glitch_back_wait", {29'd0, state}, 32'd1);
    cyc(7);
    chk("glitch_state_pre", {29'd0, state}, 32'd2);
    chk("glitch_ready_pre", {31'd0, ready}, 32'd0);
    cyc(1);
    chk("glitch_ready", {31'd0, ready}, 32'd1);
    chk("glitch_retry", {24'd0, retry_cnt}, 32'd0);

    // Loss of lock in RUN.
    pll_locked = 1'b0;
    cyc(2);
    chk("loss_ready_k2", {31'd0, ready}, 32'd1);
    cyc(1);
    chk("loss_ready_k3",    {31'd0, ready}, 32'd0);
    chk("loss_user_rst_k3", {31'd0, user_rst}, 32'd1);
    chk("loss_state_k3",    {29'd0, state}, 32'd0);
    chk("loss_cnt_k3",      {24'd0, lock_loss_cnt}, 32'd1);
    for (int k = 4; k <= 7; k++) begin
      cyc(1);
      chk($sformatf("loss_pll_rst_%0d", k), {31'd0, pll_rst}, {31'd0, (k <= 6)});
    end
    chk("loss_state_k7", {29'd0, state}, 32'd1);
    pll_locked = 1'b1;
    wait_state(3'd3, 40, "loss_relock");

    // sw_relock in the same cycle RUN would see the lock drop.
    pll_locked = 1'b0;
    cyc(2);
    sw_relock = 1'b1;
    cyc(1);
    sw_relock = 1'b0;
    chk("swr_run_state",    {29'd0, state}, 32'd0);
    chk("swr_run_loss",     {24'd0, lock_loss_cnt}, 32'd1);
    chk("swr_run_user_rst", {31'd0, user_rst}, 32'd1);
    pll_locked = 1'b1;
    wait_state(3'd3, 40, "swr_run_relock");

    // Timeout to FAIL with lock held low.
    rst = 1'b1; pll_locked = 1'b0;
    cyc(1);
    rst = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      cyc(1);
      exp_prst = (k <= 3) || (k >= 24 && k <= 27) || (k >= 48);
      chk($sformatf("to_pll_rst_%0d", k), {31'd0, pll_rst}, {31'd0, exp_prst});
      if (k == 24) chk("to_retry_1", {24'd0, retry_cnt}, 32'd1);
    end
    chk("to_state",    {29'd0, state}, 32'd4);
    chk("to_fail",     {31'd0, fail}, 32'd1);
    chk("to_retry",    {24'd0, retry_cnt}, 32'd2);
    chk("to_user_rst", {31'd0, user_rst}, 32'd1);

    // sw_relock out of FAIL.
    sw_relock = 1'b1;
    cyc(1);
    sw_relock = 1'b0;
    chk("swr_fail_state",   {29'd0, state}, 32'd0);
    chk("swr_fail_fail",    {31'd0, fail}, 32'd0);
    chk("swr_fail_retry",   {24'd0, retry_cnt}, 32'd0);
    chk("swr_fail_pll_rst", {31'd0, pll_rst}, 32'd1);
    pll_locked = 1'b1;
    wait_state(3'd3, 40, "swr_fail_relock");
    chk("swr_fail_ready", {31'd0, ready}, 32'd1);

    // 300 lock losses saturate the loss counter.
    to_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      cyc(3);
      pll_locked = 1'b1;
      n = 0;
      while (ready !== 1'b1 && n < 40) begin
        cyc(1);
        n++;
      end
      if (ready !== 1'b1) to_cnt++;
    end
    chk("sat_relock_timeouts", to_cnt, 32'd0);
    chk("sat_loss", {24'd0, lock_loss_cnt}, 32'd255);

    // Asynchronous reset in the middle of STABLE.
    pll_locked = 1'b0;
    cyc(3);
    pll_locked = 1'b1;
    wait_state(3'd2, 40, "arst_reach_stable");
    cyc(2);
    #2 rst = 1'b1;
    #1;
    chk("arst_pll_rst",  {31'd0, pll_rst}, 32'd1);
    chk("arst_state",    {29'd0, state}, 32'd0);
    chk("arst_user_rst", {31'd0, user_rst}, 32'd1);
    chk("arst_retry",    {24'd0, retry_cnt}, 32'd0);
    chk("arst_loss",     {24'd0, lock_loss_cnt}, 32'd0);
    @(negedge refclk);
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      chk($sformatf("arst_pulse_%0d", k), {31'd0, pll_rst}, {31'd0, (k <= 3)});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
